// File: rtl/ram_bist_ctrl.sv
// March/data BIST initiator for the 16x8 synchronous RAM.
// Six 16-op phases, one-cycle read latency compare, first-fail capture.
module ram_bist_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bg_pat,
  output logic       ram_wr,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [3:0] fail_addr,
  output logic [7:0] fail_exp,
  output logic [7:0] fail_got
);

  typedef enum logic [3:0] {
    IDLE, W_BG, R_BG, W_INV, R_INV, W_ADR, R_ADR, FIN, DONE
  } state_t;

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [7:0] pat, pat_n;
  logic       accept;

  logic       cmp_vld, cmp_vld_n;
  logic [7:0] cmp_exp, cmp_exp_n;
  logic [3:0] cmp_addr;
  logic       mism;

  logic       wr_n, busy_n, done_n, pass_n;
  logic [3:0] addr_n, a_n;
  logic [7:0] din_n;
  logic [5:0] err_n;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      pat   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      pat   <= pat_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pat_n   = pat;
    unique case (state)
      IDLE: if (start) begin
        state_n = W_BG;
        idx_n   = '0;
        pat_n   = bg_pat;
      end
      W_BG, R_BG, W_INV, R_INV, W_ADR, R_ADR: begin
        idx_n = idx + 4'd1;
        if (idx == 4'd15) begin
          unique case (state)
            W_BG:    state_n = R_BG;
            R_BG:    state_n = W_INV;
            W_INV:   state_n = R_INV;
            R_INV:   state_n = W_ADR;
            W_ADR:   state_n = R_ADR;
            default: state_n = FIN;
          endcase
        end
      end
      FIN:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed for the coming cycle, then registered.
  always_comb begin
    wr_n   = 1'b0;
    addr_n = ram_addr;
    din_n  = '0;
    a_n    = (state_n == W_INV || state_n == R_INV) ? ~idx_n : idx_n;
    unique case (state_n)
      W_BG: begin
        wr_n   = 1'b1;
        addr_n = a_n;
        din_n  = pat_n;
      end
      W_INV: begin
        wr_n   = 1'b1;
        addr_n = a_n;
        din_n  = ~pat_n;
      end
      W_ADR: begin
        wr_n   = 1'b1;
        addr_n = a_n;
        din_n  = {a_n, ~a_n};
      end
      R_BG, R_INV, R_ADR: addr_n = a_n;
      default: ;
    endcase
    busy_n = !(state_n == IDLE || state_n == DONE);
    done_n = (state_n == DONE);

    cmp_vld_n = 1'b0;
    cmp_exp_n = '0;
    unique case (state)
      R_BG: begin
        cmp_vld_n = 1'b1;
        cmp_exp_n = pat;
      end
      R_INV: begin
        cmp_vld_n = 1'b1;
        cmp_exp_n = ~pat;
      end
      R_ADR: begin
        cmp_vld_n = 1'b1;
        cmp_exp_n = {ram_addr, ~ram_addr};
      end
      default: ;
    endcase

    mism  = cmp_vld && (ram_dout != cmp_exp);
    err_n = err_cnt;
    if (accept)
      err_n = '0;
    else if (mism && err_cnt != 6'd63)
      err_n = err_cnt + 6'd1;

    pass_n = pass;
    if (accept)
      pass_n = 1'b0;
    else if (state_n == DONE)
      pass_n = (err_n == 6'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      cmp_vld   <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
    end else begin
      ram_wr   <= wr_n;
      ram_addr <= addr_n;
      ram_din  <= din_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      err_cnt  <= err_n;
      cmp_vld  <= cmp_vld_n;
      cmp_exp  <= cmp_exp_n;
      cmp_addr <= ram_addr;
      if (accept) begin
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else if (mism && err_cnt == 6'd0) begin
        fail_addr <= cmp_addr;
        fail_exp  <= cmp_exp;
        fail_got  <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: faulty behavioural RAM plus
// an array-level reference model of the march test.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bg_pat = '0;
  logic       ram_wr;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = '0;
  logic       busy, done, pass;
  logic [5:0] err_cnt;
  logic [3:0] fail_addr;
  logic [7:0] fail_exp, fail_got;

  int passed = 0;
  int total = 0;

  ram_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bg_pat(bg_pat),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clk = ~clk;

  // fault kinds: 0 none, 1 stuck data bit, 2 address bit stuck-at-0
  int         fk = 0;
  logic [3:0] fa = '0;
  int         fb = 0;
  logic       fv = 1'b0;
  int         ab = 3;
  logic [7:0] mem [16];

  function automatic logic [3:0] phys(input logic [3:0] a);
    logic [3:0] p = a;
    if (fk == 2) p[ab] = 1'b0;
    return p;
  endfunction

  function automatic logic [7:0] rdv(input logic [7:0] v,
                                     input logic [3:0] pa);
    logic [7:0] r = v;
    if (fk == 1 && pa == fa) r[fb] = fv;
    return r;
  endfunction

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (ram_wr) mem[phys(ram_addr)] <= ram_din;
    else ram_dout <= rdv(mem[phys(ram_addr)], phys(ram_addr));
  end

  // Operation i of the 96-op test sequence.
  function automatic void exp_op(input int i, input logic [7:0] p,
      output logic w, output logic [3:0] a, output logic [7:0] d);
    int ph = i / 16;
    int j = i % 16;
    a = (ph == 2 || ph == 3) ? 4'(15 - j) : 4'(j);
    w = (ph % 2) == 0;
    case (ph)
      0, 1: d = p;
      2, 3: d = ~p;
      default: d = {a, ~a};
    endcase
  endfunction

  int         m_err;
  logic [3:0] m_fa;
  logic [7:0] m_fe, m_fg;

  task automatic model_run(input logic [7:0] p);
    logic [7:0] m [16];
    logic w;
    logic [3:0] a;
    logic [7:0] d, got;
    for (int k = 0; k < 16; k++) m[k] = '0;
    m_err = 0; m_fa = '0; m_fe = '0; m_fg = '0;
    for (int i = 0; i < 96; i++) begin
      exp_op(i, p, w, a, d);
      if (w) m[phys(a)] = d;
      else begin
        got = rdv(m[phys(a)], phys(a));
        if (got != d) begin
          if (m_err == 0) begin
            m_fa = a; m_fe = d; m_fg = got;
          end
          m_err++;
        end
      end
    end
  endtask

  logic       busy_t [100];
  logic       done_t [100];
  logic       wr_t   [100];
  logic [3:0] addr_t [100];
  logic [7:0] din_t  [100];
  logic       r_pass;
  logic [5:0] r_err;
  logic [3:0] r_fa;
  logic [7:0] r_fe, r_fg;

  task automatic do_run(input logic [7:0] p, input int p1, input int p2);
    @(negedge clk);
    start = 1'b1;
    bg_pat = p;
    @(posedge clk);
    #1 start = 1'b0;
    bg_pat = $urandom;
    for (int c = 1; c <= 99; c++) begin
      @(negedge clk);
      busy_t[c] = busy; done_t[c] = done;
      wr_t[c] = ram_wr; addr_t[c] = ram_addr; din_t[c] = ram_din;
      if (c == 98) begin
        r_pass = pass; r_err = err_cnt;
        r_fa = fail_addr; r_fe = fail_exp; r_fg = fail_got;
      end
      start = (c == p1 || c == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, pass, ram_wr, ram_addr, ram_din, err_cnt,
         fail_addr, fail_exp, fail_got} !== 42'd0) begin
      $display("FAIL reset_state outputs got busy=%b done=%b wr=%b err=%0d want all 0",
               busy, done, ram_wr, err_cnt);
    end else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ram_wr !== 1'b0) begin
      $display("FAIL idle_after_reset busy=%b wr=%b want 0 0", busy, ram_wr);
    end else passed++;
  endtask

  task automatic test_fault_free;
    logic w;
    logic [3:0] a;
    logic [7:0] d;
    int bad_b = 0, bad_t = 0;
    fk = 0;
    do_run(8'h55, -1, -1);
    for (int c = 1; c <= 99; c++)
      if (busy_t[c] !== (c <= 97) || done_t[c] !== (c == 98)) bad_b++;
    total++;
    if (bad_b != 0) $display("FAIL ff_busy_done bad_cycles=%0d want 0", bad_b);
    else passed++;
    for (int c = 1; c <= 96; c++) begin
      exp_op(c - 1, 8'h55, w, a, d);
      if (wr_t[c] !== w || addr_t[c] !== a || din_t[c] !== (w ? d : 8'h00)) begin
        bad_t++;
        if (bad_t < 4)
          $display("FAIL ff_trace c=%0d got wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                   c, wr_t[c], addr_t[c], din_t[c], w, a, (w ? d : 8'h00));
      end
    end
    total++;
    if (bad_t != 0) $display("FAIL ff_trace_total bad=%0d want 0", bad_t);
    else passed++;
    total++;
    if (wr_t[97] !== 1'b0 || wr_t[98] !== 1'b0 || addr_t[98] !== 4'd15 ||
        din_t[98] !== 8'h00)
      $display("FAIL ff_fin_done wr97=%b wr98=%b a98=%h d98=%h want 0 0 f 00",
               wr_t[97], wr_t[98], addr_t[98], din_t[98]);
    else passed++;
    total++;
    if (r_pass !== 1'b1 || r_err !== 6'd0)
      $display("FAIL ff_result pass=%b err=%0d want 1 0", r_pass, r_err);
    else passed++;
  endtask

  task automatic test_stuck_bit;
    fk = 1; fa = 4'd3; fb = 0; fv = 1'b1;
    do_run(8'h00, -1, -1);
    total++;
    if (r_err !== 6'd2 || r_pass !== 1'b0)
      $display("FAIL sb_count err=%0d pass=%b want 2 0", r_err, r_pass);
    else passed++;
    total++;
    if (r_fa !== 4'd3 || r_fe !== 8'h00 || r_fg !== 8'h01)
      $display("FAIL sb_first a=%h e=%h g=%h want 3 00 01", r_fa, r_fe, r_fg);
    else passed++;
    fk = 0;
  endtask

  task automatic test_addr_fault;
    fk = 2; ab = 3;
    do_run(8'hA5, -1, -1);
    total++;
    if (r_err !== 6'd8 || r_pass !== 1'b0)
      $display("FAIL af_count err=%0d pass=%b want 8 0", r_err, r_pass);
    else passed++;
    total++;
    if (r_fa !== 4'd0 || r_fe !== 8'h0F || r_fg !== 8'h87)
      $display("FAIL af_first a=%h e=%h g=%h want 0 0f 87", r_fa, r_fe, r_fg);
    else passed++;
    fk = 0;
  endtask

  task automatic test_start_ignored;
    int bad = 0;
    fk = 0;
    do_run(8'h3C, 10, 98);
    for (int c = 1; c <= 99; c++)
      if (busy_t[c] !== (c <= 97) || done_t[c] !== (c == 98)) bad++;
    total++;
    if (bad != 0 || r_pass !== 1'b1)
      $display("FAIL ignore_start bad_cycles=%0d pass=%b want 0 1", bad, r_pass);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0)
      $display("FAIL ignore_done_start busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_midrun_reset;
    fk = 1; fa = 4'd5; fb = 7; fv = 1'b0;
    @(negedge clk);
    start = 1'b1; bg_pat = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, pass, ram_wr, ram_addr, ram_din, err_cnt,
         fail_addr, fail_exp, fail_got} !== 42'd0)
      $display("FAIL midrun_reset busy=%b wr=%b a=%h err=%0d want all 0",
               busy, ram_wr, ram_addr, err_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL post_reset_busy busy=%b want 0", busy);
    else passed++;
    fk = 0;
    do_run(8'hFF, -1, -1);
    total++;
    if (r_pass !== 1'b1 || r_err !== 6'd0 || done_t[98] !== 1'b1 ||
        {r_fa, r_fe, r_fg} !== 20'd0 || wr_t[1] !== 1'b1 || addr_t[1] !== 4'd0)
      $display("FAIL rerun pass=%b err=%0d done98=%b fa=%h wr1=%b a1=%h want 1 0 1 0 1 0",
               r_pass, r_err, done_t[98], r_fa, wr_t[1], addr_t[1]);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int dc [$];
    int npass = 0;
    fk = 0;
    @(negedge clk);
    start = 1'b1; bg_pat = 8'h69;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done) begin
        dc.push_back(c);
        if (pass) npass++;
      end
      start = (c < 250);
    end
    start = 1'b0;
    total++;
    if (dc.size() != 3 || dc[0] != 98 || dc[1] != 197 || dc[2] != 296)
      $display("FAIL b2b_done n=%0d first=%0d want 3 at 98 197 296",
               dc.size(), (dc.size() > 0) ? dc[0] : -1);
    else passed++;
    total++;
    if (npass != 3) $display("FAIL b2b_pass got=%0d want 3", npass);
    else passed++;
  endtask

  task automatic test_random;
    logic [7:0] p;
    for (int t = 0; t < 8; t++) begin
      p = 8'($urandom);
      fk = int'($urandom_range(0, 2));
      fa = 4'($urandom); fb = int'($urandom_range(0, 7));
      fv = 1'($urandom); ab = int'($urandom_range(0, 3));
      model_run(p);
      do_run(p, -1, -1);
      total++;
      if (r_err !== 6'(m_err) || r_pass !== (m_err == 0))
        $display("FAIL rnd%0d_count fk=%0d p=%h err=%0d pass=%b want %0d %0b",
                 t, fk, p, r_err, r_pass, m_err, (m_err == 0));
      else passed++;
      total++;
      if (r_fa !== m_fa || r_fe !== m_fe || r_fg !== m_fg)
        $display("FAIL rnd%0d_first got %h/%h/%h want %h/%h/%h",
                 t, r_fa, r_fe, r_fg, m_fa, m_fe, m_fg);
      else passed++;
    end
    fk = 0;
  endtask

  initial begin
    test_reset;
    test_fault_free;
    test_stuck_bit;
    test_addr_fault;
    test_start_ignored;
    test_midrun_reset;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
